// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle control unit: state codes, instruction
// class/sub encodings, ALU opcodes, write-back selects and the decoded control bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_e;

  localparam logic [2:0] CLS_JUMP = 3'b000;
  localparam logic [2:0] CLS_ALU  = 3'b001;
  localparam logic [2:0] CLS_ALUI = 3'b010;
  localparam logic [2:0] CLS_MEM  = 3'b100;
  localparam logic [2:0] CLS_LINK = 3'b110;

  localparam logic [2:0] SUB_JF  = 3'b000;
  localparam logic [2:0] SUB_JT  = 3'b001;
  localparam logic [2:0] SUB_JMP = 3'b010;
  localparam logic [2:0] SUB_JAL = 3'b011;
  localparam logic [2:0] SUB_JR  = 3'b100;

  localparam logic [4:0] OP_ADD     = 5'b00000;
  localparam logic [4:0] OP_PASSB   = 5'b10011;
  localparam logic [4:0] OP_MEMADDR = 5'b10000;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC1 = 2'b10;

  // Width-independent part of the decode result; selects and immediate travel separately.
  typedef struct packed {
    logic       legal;
    logic       reg_write;
    logic       is_mem;
    logic       store;
    logic       mux_b_sel;
    logic [1:0] wb_sel;
    logic [4:0] ula_op;
    logic       jump_en;
    logic       jump_pol;
    logic [2:0] jump_cond;
  } ctrl_t;

endpackage

// File: rtl/unidade_controle_mc_if.sv
// Control-unit bus: instruction/data memory handshakes plus every datapath control line.
// master = control unit, slave = datapath/memory side.
interface unidade_controle_mc_if #(
  parameter int REG_AW  = 4,
  parameter int CONST_W = 16
);

  logic [31:0]        instrucao;
  logic               imem_ready;
  logic               dmem_ready;
  logic               ir_load;
  logic               pc_en;
  logic [REG_AW-1:0]  sel_c;
  logic [REG_AW-1:0]  sel_a;
  logic [REG_AW-1:0]  sel_b;
  logic               reg_we;
  logic               mux_b_sel;
  logic [1:0]         wb_sel;
  logic [4:0]         ula_op;
  logic [CONST_W-1:0] constante;
  logic               dmem_req;
  logic               dmem_we;
  logic               jump_en;
  logic               jump_pol;
  logic [2:0]         jump_cond;
  logic               illegal_op;
  logic [2:0]         estado;

  modport master (
    input  instrucao, imem_ready, dmem_ready,
    output ir_load, pc_en, sel_c, sel_a, sel_b, reg_we, mux_b_sel, wb_sel, ula_op,
           constante, dmem_req, dmem_we, jump_en, jump_pol, jump_cond, illegal_op, estado
  );

  modport slave (
    output instrucao, imem_ready, dmem_ready,
    input  ir_load, pc_en, sel_c, sel_a, sel_b, reg_we, mux_b_sel, wb_sel, ula_op,
           constante, dmem_req, dmem_we, jump_en, jump_pol, jump_cond, illegal_op, estado
  );

endinterface

// File: rtl/ctrl_decode.sv
// Combinational decode of the latched instruction word into a control bundle and legal flag.
// Build option CTRL_JAL_EN: when defined, class 110 (jump-and-link / jump-register) is legal.
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int CONST_W  = 16,
  parameter int LINK_REG = 15
) (
  input  logic [31:0]        ir,
  output ctrl_t              ctrl,
  output logic [REG_AW-1:0]  sel_c,
  output logic [REG_AW-1:0]  sel_a,
  output logic [REG_AW-1:0]  sel_b,
  output logic [CONST_W-1:0] constante
);

  logic [2:0] cls;
  logic [2:0] sub;
  logic       unused_ir;

  assign cls = ir[31:29];
  assign sub = ir[26:24];
  assign unused_ir = ^{ir[28:27], ir[23], ir[19]};

`ifndef CTRL_JAL_EN
  localparam int unused_link = LINK_REG;
`endif

  always_comb begin
    ctrl      = '0;
    sel_c     = ir[20 +: REG_AW];
    sel_a     = ir[16 +: REG_AW];
    sel_b     = ir[12 +: REG_AW];
    constante = '0;
    case (cls)
      CLS_ALU: begin
        ctrl.legal     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU;
        ctrl.ula_op    = {cls, ir[25:24]};
      end
      CLS_ALUI: begin
        ctrl.legal     = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.wb_sel    = WB_ALU;
        ctrl.mux_b_sel = 1'b1;
        ctrl.ula_op    = {cls, ir[25:24]};
        constante      = ir[CONST_W-1:0];
      end
      CLS_MEM: begin
        ctrl.legal     = 1'b1;
        ctrl.is_mem    = 1'b1;
        ctrl.store     = sub[0];
        ctrl.reg_write = ~sub[0];
        ctrl.wb_sel    = sub[0] ? WB_ALU : WB_MEM;
        ctrl.ula_op    = OP_MEMADDR;
      end
      CLS_JUMP: begin
        case (sub)
          SUB_JF, SUB_JT: begin
            ctrl.legal     = 1'b1;
            ctrl.jump_en   = 1'b1;
            ctrl.jump_cond = ir[14:12];
            ctrl.jump_pol  = sub[0];
          end
          SUB_JMP: begin
            ctrl.legal     = 1'b1;
            ctrl.jump_en   = 1'b1;
            ctrl.jump_pol  = 1'b1;
            ctrl.mux_b_sel = 1'b1;
            ctrl.ula_op    = OP_ADD;
            constante      = CONST_W'(ir[11:0]);
          end
          default: ;
        endcase
      end
`ifdef CTRL_JAL_EN
      CLS_LINK: begin
        case (sub)
          SUB_JAL: begin
            ctrl.legal     = 1'b1;
            ctrl.jump_en   = 1'b1;
            ctrl.jump_pol  = 1'b1;
            ctrl.reg_write = 1'b1;
            ctrl.wb_sel    = WB_PC1;
            ctrl.ula_op    = OP_PASSB;
            sel_c          = REG_AW'(LINK_REG);
          end
          SUB_JR: begin
            ctrl.legal    = 1'b1;
            ctrl.jump_en  = 1'b1;
            ctrl.jump_pol = 1'b1;
            ctrl.ula_op   = OP_PASSB;
          end
          default: ;
        endcase
      end
`endif
      default: ;
    endcase

    // Illegal encodings become a clean NOP: nothing selected, nothing written.
    if (!ctrl.legal) begin
      ctrl      = '0;
      sel_c     = '0;
      sel_a     = '0;
      sel_b     = '0;
      constante = '0;
    end
  end

endmodule

// File: rtl/unidade_controle_mc.sv
// Multi-cycle control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with registered Moore outputs.
// Build option CTRL_JAL_EN (handled in ctrl_decode) enables the jump-and-link class.
module unidade_controle_mc
  import ctrl_pkg::*;
#(
  parameter int REG_AW   = 4,
  parameter int CONST_W  = 16,
  parameter int LINK_REG = 15
) (
  input logic clock,
  input logic reset,
  unidade_controle_mc_if.master bus
);

  localparam logic [2:0] S_FETCH  = FETCH;
  localparam logic [2:0] S_DECODE = DECODE;
  localparam logic [2:0] S_EXEC   = EXEC;
  localparam logic [2:0] S_MEM    = MEM;
  localparam logic [2:0] S_WB     = WB;

  logic [2:0]         state;
  logic [2:0]         next_state;
  logic [31:0]        ir;
  logic               capture;
  ctrl_t              dec;
  logic [REG_AW-1:0]  dec_sel_c;
  logic [REG_AW-1:0]  dec_sel_a;
  logic [REG_AW-1:0]  dec_sel_b;
  logic [CONST_W-1:0] dec_constante;

  logic               ir_load;
  logic               pc_en;
  logic               reg_we;
  logic               mux_b_sel;
  logic               dmem_req;
  logic               dmem_we;
  logic               jump_en;
  logic               jump_pol;
  logic               illegal_op;
  logic [REG_AW-1:0]  sel_c;
  logic [REG_AW-1:0]  sel_a;
  logic [REG_AW-1:0]  sel_b;
  logic [1:0]         wb_sel;
  logic [4:0]         ula_op;
  logic [CONST_W-1:0] constante;
  logic [2:0]         jump_cond;

  ctrl_decode #(
    .REG_AW   (REG_AW),
    .CONST_W  (CONST_W),
    .LINK_REG (LINK_REG)
  ) u_decode (
    .ir        (ir),
    .ctrl      (dec),
    .sel_c     (dec_sel_c),
    .sel_a     (dec_sel_a),
    .sel_b     (dec_sel_b),
    .constante (dec_constante)
  );

  // FETCH spends one extra cycle with ir_load high so DECODE sees a settled IR.
  assign capture = (state == S_FETCH) && !ir_load && bus.imem_ready;

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (ir_load) next_state = S_DECODE;
      S_DECODE: next_state = dec.legal ? S_EXEC : S_WB;
      S_EXEC:   next_state = dec.is_mem ? S_MEM : S_WB;
      S_MEM:    if (bus.dmem_ready) next_state = S_WB;
      S_WB:     next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // Every output is registered from next_state so it lines up with estado.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_FETCH;
      ir         <= '0;
      ir_load    <= 1'b0;
      pc_en      <= 1'b0;
      reg_we     <= 1'b0;
      illegal_op <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      sel_c      <= '0;
      sel_a      <= '0;
      sel_b      <= '0;
      constante  <= '0;
      wb_sel     <= WB_ALU;
      ula_op     <= '0;
      mux_b_sel  <= 1'b0;
      jump_en    <= 1'b0;
      jump_pol   <= 1'b0;
      jump_cond  <= '0;
    end else begin
      state      <= next_state;
      ir_load    <= capture;
      if (capture) ir <= bus.instrucao;
      illegal_op <= (next_state == S_DECODE) && !dec.legal;
      dmem_req   <= (next_state == S_MEM);
      dmem_we    <= (next_state == S_MEM) && dec.store;
      pc_en      <= (next_state == S_WB);
      reg_we     <= (next_state == S_WB) && dec.legal && dec.reg_write;

      if (next_state == S_DECODE) begin
        sel_c     <= dec_sel_c;
        sel_a     <= dec_sel_a;
        sel_b     <= dec_sel_b;
        constante <= dec_constante;
        wb_sel    <= dec.wb_sel;
      end else if (next_state == S_FETCH) begin
        sel_c     <= '0;
        sel_a     <= '0;
        sel_b     <= '0;
        constante <= '0;
        wb_sel    <= WB_ALU;
      end

      if (next_state == S_EXEC) begin
        ula_op    <= dec.ula_op;
        mux_b_sel <= dec.mux_b_sel;
        jump_en   <= dec.jump_en;
        jump_pol  <= dec.jump_pol;
        jump_cond <= dec.jump_cond;
      end else if (next_state == S_FETCH) begin
        ula_op    <= '0;
        mux_b_sel <= 1'b0;
        jump_en   <= 1'b0;
        jump_pol  <= 1'b0;
        jump_cond <= '0;
      end
    end
  end

  assign bus.ir_load    = ir_load;
  assign bus.pc_en      = pc_en;
  assign bus.sel_c      = sel_c;
  assign bus.sel_a      = sel_a;
  assign bus.sel_b      = sel_b;
  assign bus.reg_we     = reg_we;
  assign bus.mux_b_sel  = mux_b_sel;
  assign bus.wb_sel     = wb_sel;
  assign bus.ula_op     = ula_op;
  assign bus.constante  = constante;
  assign bus.dmem_req   = dmem_req;
  assign bus.dmem_we    = dmem_we;
  assign bus.jump_en    = jump_en;
  assign bus.jump_pol   = jump_pol;
  assign bus.jump_cond  = jump_cond;
  assign bus.illegal_op = illegal_op;
  assign bus.estado     = state;

endmodule

// File: tb/tb_unidade_controle_mc.sv
// Table-driven bench for unidade_controle_mc: one record per instruction walked through
// the whole FETCH..WB sequence, plus hand-written reset/wait corner cases.
module tb_unidade_controle_mc;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_fail;

  unidade_controle_mc_if #(.REG_AW(4), .CONST_W(16)) bus ();

  unidade_controle_mc #(
    .REG_AW   (4),
    .CONST_W  (16),
    .LINK_REG (15)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  typedef struct {
    logic [31:0] instr;
    int          waits;
    logic        illegal;
    logic        is_mem;
    logic [3:0]  sel_c;
    logic [3:0]  sel_a;
    logic [3:0]  sel_b;
    logic [15:0] constante;
    logic [4:0]  ula_op;
    logic        mux_b;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic        dmem_we;
    logic        jump_en;
    logic        jump_pol;
    logic [2:0]  jump_cond;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs[NVEC];

  function automatic vec_t make_vec(
    input logic [31:0] instr, input int waits, input logic illegal, input logic is_mem,
    input logic [3:0] sel_c, input logic [3:0] sel_a, input logic [3:0] sel_b,
    input logic [15:0] constante, input logic [4:0] ula_op, input logic mux_b,
    input logic [1:0] wb_sel, input logic reg_we, input logic dmem_we,
    input logic jump_en, input logic jump_pol, input logic [2:0] jump_cond);
    vec_t v;
    v.instr = instr;     v.waits = waits;   v.illegal = illegal; v.is_mem = is_mem;
    v.sel_c = sel_c;     v.sel_a = sel_a;   v.sel_b = sel_b;     v.constante = constante;
    v.ula_op = ula_op;   v.mux_b = mux_b;   v.wb_sel = wb_sel;   v.reg_we = reg_we;
    v.dmem_we = dmem_we; v.jump_en = jump_en; v.jump_pol = jump_pol; v.jump_cond = jump_cond;
    return v;
  endfunction

  function automatic vec_t illegal_vec(input logic [31:0] instr);
    return make_vec(instr, 0, 1, 0, 0, 0, 0, 16'h0, 5'b0, 0, 2'b00, 0, 0, 0, 0, 3'b000);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  // Runs one instruction from FETCH to the FETCH after WB, checking each state's outputs.
  task automatic apply_stimulus(input vec_t v, input string tag);
    int got;
    instrucao_drive(v.instr);
    bus.imem_ready = 1'b1;
    bus.dmem_ready = v.is_mem ? 1'b0 : 1'b1;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.ir_load === 1'b1) begin
        got = 1;
        break;
      end
    end
    check_output({tag, " ir_load seen"}, 32'(got), 32'd1);
    if (got == 0) return;
    check_output({tag, " c0 estado"}, 32'(bus.estado), 32'd0);
    instrucao_drive(32'hFFFF_FFFF);

    step();
    check_output({tag, " decode estado"}, 32'(bus.estado), 32'd1);
    check_output({tag, " illegal_op"}, 32'(bus.illegal_op), 32'(v.illegal));
    check_output({tag, " decode ir_load"}, 32'(bus.ir_load), 32'd0);
    if (v.illegal) begin
      step();
      check_output({tag, " nop estado"}, 32'(bus.estado), 32'd4);
      check_output({tag, " nop pc_en"}, 32'(bus.pc_en), 32'd1);
      check_output({tag, " nop reg_we"}, 32'(bus.reg_we), 32'd0);
      check_output({tag, " nop dmem_req"}, 32'(bus.dmem_req), 32'd0);
      check_output({tag, " nop illegal_op"}, 32'(bus.illegal_op), 32'd0);
      step();
      check_output({tag, " post estado"}, 32'(bus.estado), 32'd0);
      return;
    end
    check_output({tag, " sel_a"}, 32'(bus.sel_a), 32'(v.sel_a));
    check_output({tag, " sel_b"}, 32'(bus.sel_b), 32'(v.sel_b));
    check_output({tag, " constante"}, 32'(bus.constante), 32'(v.constante));

    step();
    check_output({tag, " exec estado"}, 32'(bus.estado), 32'd2);
    check_output({tag, " ula_op"}, 32'(bus.ula_op), 32'(v.ula_op));
    check_output({tag, " mux_b_sel"}, 32'(bus.mux_b_sel), 32'(v.mux_b));
    check_output({tag, " jump_en"}, 32'(bus.jump_en), 32'(v.jump_en));
    check_output({tag, " jump_pol"}, 32'(bus.jump_pol), 32'(v.jump_pol));
    check_output({tag, " jump_cond"}, 32'(bus.jump_cond), 32'(v.jump_cond));

    if (v.is_mem) begin
      step();
      check_output({tag, " mem estado"}, 32'(bus.estado), 32'd3);
      check_output({tag, " dmem_req"}, 32'(bus.dmem_req), 32'd1);
      check_output({tag, " dmem_we"}, 32'(bus.dmem_we), 32'(v.dmem_we));
      for (int w = 0; w < v.waits; w++) begin
        step();
        check_output({tag, " wait estado"}, 32'(bus.estado), 32'd3);
        check_output({tag, " wait dmem_req"}, 32'(bus.dmem_req), 32'd1);
        check_output({tag, " wait dmem_we"}, 32'(bus.dmem_we), 32'(v.dmem_we));
      end
      bus.dmem_ready = 1'b1;
      step();
      bus.dmem_ready = 1'b0;
    end else begin
      step();
    end

    check_output({tag, " wb estado"}, 32'(bus.estado), 32'd4);
    check_output({tag, " wb pc_en"}, 32'(bus.pc_en), 32'd1);
    check_output({tag, " wb reg_we"}, 32'(bus.reg_we), 32'(v.reg_we));
    check_output({tag, " wb wb_sel"}, 32'(bus.wb_sel), 32'(v.wb_sel));
    check_output({tag, " wb sel_c"}, 32'(bus.sel_c), 32'(v.sel_c));
    check_output({tag, " wb dmem_req"}, 32'(bus.dmem_req), 32'd0);

    step();
    check_output({tag, " post estado"}, 32'(bus.estado), 32'd0);
    check_output({tag, " post pc_en"}, 32'(bus.pc_en), 32'd0);
    check_output({tag, " post reg_we"}, 32'(bus.reg_we), 32'd0);
    check_output({tag, " post ir_load"}, 32'(bus.ir_load), 32'd0);
  endtask

  task automatic instrucao_drive(input logic [31:0] value);
    bus.instrucao = value;
  endtask

  initial begin
    int got;
    n_checks = 0;
    n_fail   = 0;

    //                     instr        wt il mem sc  sa  sb  const     ula       mb wb     we dwe je jp jc
    vecs[0]  = make_vec(32'h2012_3000, 0, 0, 0, 1,  2,  3,  16'h0000, 5'b00100, 0, 2'b00, 1, 0, 0, 0, 3'b000);
    vecs[1]  = make_vec(32'h4B56_ABCD, 0, 0, 0, 5,  6,  10, 16'hABCD, 5'b01011, 1, 2'b00, 1, 0, 0, 0, 3'b000);
    vecs[2]  = make_vec(32'h8045_0000, 3, 0, 1, 4,  5,  0,  16'h0000, 5'b10000, 0, 2'b01, 1, 0, 0, 0, 3'b000);
    vecs[3]  = make_vec(32'h8100_0000, 0, 0, 1, 0,  0,  0,  16'h0000, 5'b10000, 0, 2'b00, 0, 1, 0, 0, 3'b000);
    vecs[4]  = make_vec(32'h8F23_4000, 1, 0, 1, 2,  3,  4,  16'h0000, 5'b10000, 0, 2'b00, 0, 1, 0, 0, 3'b000);
    vecs[5]  = make_vec(32'h0100_5000, 0, 0, 0, 0,  0,  5,  16'h0000, 5'b00000, 0, 2'b00, 0, 0, 1, 1, 3'b101);
    vecs[6]  = make_vec(32'h0032_6000, 0, 0, 0, 3,  2,  6,  16'h0000, 5'b00000, 0, 2'b00, 0, 0, 1, 0, 3'b110);
    vecs[7]  = make_vec(32'h0200_7ABC, 0, 0, 0, 0,  0,  7,  16'h0ABC, 5'b00000, 1, 2'b00, 0, 0, 1, 1, 3'b000);
    vecs[8]  = illegal_vec(32'h6000_0000);
    vecs[9]  = illegal_vec(32'h0300_0000);
`ifdef CTRL_JAL_EN
    vecs[10] = make_vec(32'hC300_7000, 0, 0, 0, 15, 0,  7,  16'h0000, 5'b10011, 0, 2'b10, 1, 0, 1, 1, 3'b000);
    vecs[11] = make_vec(32'hC400_2000, 0, 0, 0, 0,  0,  2,  16'h0000, 5'b10011, 0, 2'b00, 0, 0, 1, 1, 3'b000);
`else
    vecs[10] = illegal_vec(32'hC300_7000);
    vecs[11] = illegal_vec(32'hC400_2000);
`endif
    vecs[12] = illegal_vec(32'hE000_0000);
    vecs[13] = make_vec(32'h3BFE_D000, 0, 0, 0, 15, 14, 13, 16'h0000, 5'b00111, 0, 2'b00, 1, 0, 0, 0, 3'b000);

    reset          = 1'b1;
    bus.instrucao  = 32'h0;
    bus.imem_ready = 1'b0;
    bus.dmem_ready = 1'b0;
    step();
    step();
    check_output("reset estado", 32'(bus.estado), 32'd0);
    check_output("reset ir_load", 32'(bus.ir_load), 32'd0);
    check_output("reset pc_en", 32'(bus.pc_en), 32'd0);
    check_output("reset reg_we", 32'(bus.reg_we), 32'd0);
    check_output("reset dmem_req", 32'(bus.dmem_req), 32'd0);
    check_output("reset dmem_we", 32'(bus.dmem_we), 32'd0);
    check_output("reset jump_en", 32'(bus.jump_en), 32'd0);
    check_output("reset illegal_op", 32'(bus.illegal_op), 32'd0);
    check_output("reset sel_c", 32'(bus.sel_c), 32'd0);
    check_output("reset ula_op", 32'(bus.ula_op), 32'd0);
    check_output("reset wb_sel", 32'(bus.wb_sel), 32'd0);
    check_output("reset constante", 32'(bus.constante), 32'd0);
    check_output("reset jump_cond", 32'(bus.jump_cond), 32'd0);
    reset = 1'b0;

    // imem wait: FETCH holds with no capture while imem_ready is low.
    bus.instrucao = 32'h2012_3000;
    for (int i = 0; i < 3; i++) begin
      step();
      check_output("imem wait estado", 32'(bus.estado), 32'd0);
      check_output("imem wait ir_load", 32'(bus.ir_load), 32'd0);
    end

    for (int i = 0; i < NVEC; i++) begin
      apply_stimulus(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in MEM with dmem_req high, then a stale dmem_ready must not advance the FSM.
    bus.instrucao  = 32'h8045_0000;
    bus.imem_ready = 1'b1;
    bus.dmem_ready = 1'b0;
    got = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.ir_load === 1'b1) begin
        got = 1;
        break;
      end
    end
    check_output("rst-mem ir_load seen", 32'(got), 32'd1);
    bus.imem_ready = 1'b0;
    step();
    step();
    step();
    check_output("rst-mem estado", 32'(bus.estado), 32'd3);
    check_output("rst-mem dmem_req", 32'(bus.dmem_req), 32'd1);
    reset = 1'b1;
    step();
    check_output("rst-mem after estado", 32'(bus.estado), 32'd0);
    check_output("rst-mem after dmem_req", 32'(bus.dmem_req), 32'd0);
    check_output("rst-mem after reg_we", 32'(bus.reg_we), 32'd0);
    reset = 1'b0;
    bus.dmem_ready = 1'b1;
    step();
    step();
    check_output("stale dmem_ready estado", 32'(bus.estado), 32'd0);
    check_output("stale dmem_ready pc_en", 32'(bus.pc_en), 32'd0);
    check_output("stale dmem_ready ir_load", 32'(bus.ir_load), 32'd0);
    bus.dmem_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
